reduction_unit: RTL and testbench
=================================

REDUCTION_UNIT -- requirements
Module: reduction_unit

Interface
REQ-001 Parameter DataWidth, 256, flit width.
REQ-002 Parameter PayloadLen, 128, payload field at bits [PayloadLen-1:0], four 32-bit lanes.
REQ-003 Parameter ReductionBitPos, 254, flit bit marking a reduction packet.
REQ-004 Parameter IndexPos, 128, reduction table index field LSB; IndexWidth 16, low 8 bits used.
REQ-005 Parameter WeightPos, 144, weight field LSB; WeightWidth 8.
REQ-006 Parameter ReductionTablesize, 256, table entries.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 in_data  input  DataWidth  flit from the priority-select mux stage.
REQ-010 in_valid  input  1  in_data valid; in_data[DataWidth-1] also set.
REQ-011 in_ready  output  1  flit accepted when in_valid && in_ready.
REQ-012 out_data  output  DataWidth  pass-through or completed reduction flit.
REQ-013 out_valid / out_ready  output / input  1 each  output handshake.
REQ-014 cfg_we, cfg_index[7:0], cfg_expect[2:0]  input  config write of expected fan-in count.

Function
REQ-015 Entry: expect(3), count(3), weight_acc(8), payload_acc(128).
REQ-016 Two stages: RR (register flit, read entry[index[7:0]]), AW (accumulate, write back or emit).
REQ-017 Non-reduction flit, or reduction flit whose entry has expect==0: out_data = flit unchanged, out_valid 2 cycles after acceptance, table untouched.
REQ-018 Reduction flit, expect!=0, count+1<expect: write back count+1, weight_acc+weight, payload_acc+payload; no output.
REQ-019 Reduction flit, count+1==expect: emit flit with header bits from the final flit, weight field = sum, payload = sum; clear count, weight_acc, payload_acc; retain expect.
REQ-020 Payload sum: per 32-bit lane, modulo 2^32, no inter-lane carry.
REQ-021 Weight sum saturates at 255.
REQ-022 count>=expect (expect lowered by config): treat as completion, emit, clear.
REQ-023 Back-to-back reduction flits to the same index: AW result forwarded into RR; no lost update, no bubble.
REQ-024 Stall: out_valid && !out_ready freezes both stages; in_ready = 0; out_data stable.
REQ-025 in_ready = 0 while cfg_we = 1.
REQ-026 Config write sets expect, clears count and accumulators at cfg_index; wins over a same-cycle AW write-back to that index, which is discarded.
REQ-027 Throughput: one flit per cycle without back-pressure.

Reset
REQ-028 While rst low: out_valid 0, in_ready 0, stage valids 0, all entries zero (expect 0 = pass-through).
REQ-029 out_data resets to 0.
REQ-030 Reset mid-operation discards in-flight flits and partial sums; no output after release until new input.
REQ-031 in_ready rises in the first cycle after rst deasserts.

Structure
REQ-032 Shared package: field positions/widths, table entry struct, 32-bit lane-add function.
REQ-033 One sub-module: reduction_table (256-entry storage, one read port, one write port, config-write priority).
REQ-034 Forwarding, saturation and emit logic in reduction_unit.

Verification
REQ-035 Non-reduction flit 0x8000...00AB, out_ready=1 -> identical flit on out_data 2 cycles later, table unchanged.
REQ-036 cfg expect=3 at index 5; three flits index 5, weights 1,2,3, lane0 payloads 10,20,30, consecutive cycles -> one flit: weight 6, lane0 60; entry 5 count 0.
REQ-037 expect=2 at index 7, weights 200 and 100 -> output weight 255; lanes 0xFFFFFFFF+2 -> lane 1, lane above unaffected.
REQ-038 Pass-through flit followed by completion, out_ready low 5 cycles -> in_ready 0, out_data held; both flits delivered in order after release.
REQ-039 Config write to index 9 in the cycle AW writes index 9 (count 1->2) -> entry 9 count 0, accumulators 0, expect new value.
REQ-040 rst low after 2 of 3 flits to index 4, then full sequence of 3 -> single output containing only the post-reset sums.

Source files
------------

// File: rtl/reduction_unit_pkg.sv
// Shared definitions for the reduction unit.
// Holds field widths, the reduction table entry layout and the lane-wise payload adder.
package reduction_unit_pkg;

  localparam int unsigned LaneW    = 32;
  localparam int unsigned NumLanes = 4;
  localparam int unsigned PayloadW = LaneW * NumLanes;
  localparam int unsigned IdxW     = 8;
  localparam int unsigned WeightW  = 8;
  localparam int unsigned CountW   = 3;

  // One reduction table entry: expected fan-in, flits seen so far, running sums.
  typedef struct packed {
    logic [CountW-1:0]   exp_cnt;
    logic [CountW-1:0]   count;
    logic [WeightW-1:0]  weight_acc;
    logic [PayloadW-1:0] payload_acc;
  } entry_t;

  // Independent 32-bit adds per lane; carries never cross lane boundaries.
  function automatic logic [PayloadW-1:0] lane_add(input logic [PayloadW-1:0] a,
                                                   input logic [PayloadW-1:0] b);
    logic [PayloadW-1:0] s;
    s = '0;
    for (int l = 0; l < NumLanes; l++) begin
      s[l*LaneW +: LaneW] = a[l*LaneW +: LaneW] + b[l*LaneW +: LaneW];
    end
    return s;
  endfunction

  // Entry image produced by a configuration write: new fan-in, everything else cleared.
  function automatic entry_t cfg_entry(input logic [CountW-1:0] e);
    entry_t r;
    r         = '0;
    r.exp_cnt = e;
    return r;
  endfunction

endpackage

// File: rtl/reduction_unit_table.sv
// Reduction table storage.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-low reset (clears every entry)
//   i_rd_idx/o_rd_entry   combinational read port
//   i_wr_en/idx/entry     pipeline write-back port
//   i_cfg_we/idx/expect   configuration write; beats a write-back to the same index
module reduction_table
  import reduction_unit_pkg::*;
#(
  parameter int unsigned Depth = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [IdxW-1:0]   i_rd_idx,
  output entry_t            o_rd_entry,
  input  logic              i_wr_en,
  input  logic [IdxW-1:0]   i_wr_idx,
  input  entry_t            i_wr_entry,
  input  logic              i_cfg_we,
  input  logic [IdxW-1:0]   i_cfg_idx,
  input  logic [CountW-1:0] i_cfg_expect
);

  entry_t r_mem [Depth];

  assign o_rd_entry = r_mem[i_rd_idx];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (i_cfg_we && (i_cfg_idx == IdxW'(i))) begin
          r_mem[i] <= cfg_entry(i_cfg_expect);
        end else if (i_wr_en && (i_wr_idx == IdxW'(i))) begin
          r_mem[i] <= i_wr_entry;
        end
      end
    end
  end

endmodule

// File: rtl/reduction_unit.sv
// Reduction unit: sums payloads and weights of flits sharing a table index and emits one
// flit when the configured fan-in is reached; all other flits pass through unchanged.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   in_data/in_valid/in_ready      input flit handshake
//   out_data/out_valid/out_ready   output flit handshake (out_data is registered)
//   cfg_we/cfg_index/cfg_expect    write of the expected fan-in for one table entry
// Pipeline: RR (flit registered, table read) -> AW (accumulate, write back or emit) -> out reg.
module reduction_unit
  import reduction_unit_pkg::*;
#(
  parameter int unsigned DataWidth          = 256,
  parameter int unsigned PayloadLen         = 128,
  parameter int unsigned ReductionBitPos    = 254,
  parameter int unsigned IndexPos           = 128,
  parameter int unsigned WeightPos          = 144,
  parameter int unsigned ReductionTablesize = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataWidth-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DataWidth-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 cfg_we,
  input  logic [IdxW-1:0]      cfg_index,
  input  logic [CountW-1:0]    cfg_expect
);

  logic                 r_in_en;
  logic                 r_rr_valid;
  logic [DataWidth-1:0] r_rr_data;
  logic                 r_aw_valid;
  logic                 r_aw_kill;
  logic [DataWidth-1:0] r_aw_data;
  entry_t               r_aw_entry;
  logic                 r_out_valid;
  logic [DataWidth-1:0] r_out_data;

  logic                 w_stall;
  logic                 w_accept;
  logic [IdxW-1:0]      w_rr_idx;
  logic [IdxW-1:0]      w_aw_idx;
  entry_t               w_tbl_entry;
  entry_t               w_rr_entry;
  entry_t               w_wb_entry;
  logic                 w_reduce;
  logic                 w_done;
  logic                 w_emit;
  logic                 w_wb_en;
  logic [CountW:0]      w_cnt_next;
  logic [WeightW:0]     w_wsum_raw;
  logic [WeightW-1:0]   w_wsum;
  logic [PayloadW-1:0]  w_psum;
  logic [DataWidth-1:0] w_emit_data;

  // A held output freezes every stage.
  assign w_stall   = r_out_valid && !out_ready;
  assign in_ready  = r_in_en && !w_stall && !cfg_we;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  assign w_rr_idx = r_rr_data[IndexPos +: IdxW];
  assign w_aw_idx = r_aw_data[IndexPos +: IdxW];

  reduction_table #(
    .Depth(ReductionTablesize)
  ) u_table (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rd_idx    (w_rr_idx),
    .o_rd_entry  (w_tbl_entry),
    .i_wr_en     (w_wb_en),
    .i_wr_idx    (w_aw_idx),
    .i_wr_entry  (w_wb_entry),
    .i_cfg_we    (cfg_we),
    .i_cfg_idx   (cfg_index),
    .i_cfg_expect(cfg_expect)
  );

  // Writes landing on the same edge the RR flit moves to AW are not yet visible in the
  // table, so bypass them; the config write takes precedence like it does in storage.
  always_comb begin
    w_rr_entry = w_tbl_entry;
    if (w_wb_en && (w_aw_idx == w_rr_idx)) begin
      w_rr_entry = w_wb_entry;
    end
    if (cfg_we && (cfg_index == w_rr_idx)) begin
      w_rr_entry = cfg_entry(cfg_expect);
    end
  end

  // AW stage arithmetic.
  assign w_reduce   = r_aw_valid && r_aw_data[ReductionBitPos] && (r_aw_entry.exp_cnt != '0);
  assign w_cnt_next = {1'b0, r_aw_entry.count} + (CountW+1)'(1);
  // >= also catches a count left above a lowered fan-in.
  assign w_done     = w_reduce && (w_cnt_next >= {1'b0, r_aw_entry.exp_cnt});
  assign w_emit     = r_aw_valid && (!w_reduce || w_done);
  assign w_wsum_raw = {1'b0, r_aw_entry.weight_acc} + {1'b0, r_aw_data[WeightPos +: WeightW]};
  assign w_wsum     = w_wsum_raw[WeightW] ? {WeightW{1'b1}} : w_wsum_raw[WeightW-1:0];
  assign w_psum     = lane_add(r_aw_entry.payload_acc, r_aw_data[PayloadLen-1:0]);
  // Kill covers a config write that hit this index while the stage was frozen.
  assign w_wb_en    = w_reduce && !w_stall && !r_aw_kill;

  always_comb begin
    w_wb_entry.exp_cnt = r_aw_entry.exp_cnt;
    if (w_done) begin
      w_wb_entry.count       = '0;
      w_wb_entry.weight_acc  = '0;
      w_wb_entry.payload_acc = '0;
    end else begin
      w_wb_entry.count       = w_cnt_next[CountW-1:0];
      w_wb_entry.weight_acc  = w_wsum;
      w_wb_entry.payload_acc = w_psum;
    end
  end

  always_comb begin
    w_emit_data = r_aw_data;
    if (w_done) begin
      w_emit_data[WeightPos +: WeightW] = w_wsum;
      w_emit_data[PayloadLen-1:0]       = w_psum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_en     <= 1'b0;
      r_rr_valid  <= 1'b0;
      r_rr_data   <= '0;
      r_aw_valid  <= 1'b0;
      r_aw_kill   <= 1'b0;
      r_aw_data   <= '0;
      r_aw_entry  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_in_en <= 1'b1;
      if (!w_stall) begin
        r_rr_valid <= w_accept;
        if (w_accept) begin
          r_rr_data <= in_data;
        end
        r_aw_valid  <= r_rr_valid;
        r_aw_data   <= r_rr_data;
        r_aw_entry  <= w_rr_entry;
        r_aw_kill   <= 1'b0;
        r_out_valid <= w_emit;
        if (w_emit) begin
          r_out_data <= w_emit_data;
        end
      end else if (cfg_we && r_aw_valid && (cfg_index == w_aw_idx)) begin
        r_aw_kill <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reduction_unit.sv
// Self-checking bench for reduction_unit: directed cases plus randomized traffic checked
// against a table/queue reference model.
module tb_reduction_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         cfg_we;
  logic [7:0]   cfg_index;
  logic [2:0]   cfg_expect;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

  // Reference model state.
  int           m_exp [256];
  int           m_cnt [256];
  int           m_w   [256];
  logic [31:0]  m_p   [256][4];
  logic [255:0] exp_q [$];

  reduction_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cfg_we    (cfg_we),
    .cfg_index (cfg_index),
    .cfg_expect(cfg_expect)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin
      m_exp[i] = 0;
      m_cnt[i] = 0;
      m_w[i]   = 0;
      for (int l = 0; l < 4; l++) m_p[i][l] = '0;
    end
  endtask

  task automatic model_apply(input logic [255:0] f);
    int           idx;
    int           c;
    int           w;
    logic [31:0]  s [4];
    logic [255:0] o;
    idx = int'(f[135:128]);
    if (!f[254] || m_exp[idx] == 0) begin
      exp_q.push_back(f);
    end else begin
      c = m_cnt[idx] + 1;
      w = m_w[idx] + int'(f[151:144]);
      if (w > 255) w = 255;
      for (int l = 0; l < 4; l++) s[l] = m_p[idx][l] + f[l*32 +: 32];
      if (c >= m_exp[idx]) begin
        o = f;
        o[151:144] = 8'(w);
        for (int l = 0; l < 4; l++) o[l*32 +: 32] = s[l];
        exp_q.push_back(o);
        m_cnt[idx] = 0;
        m_w[idx]   = 0;
        for (int l = 0; l < 4; l++) m_p[idx][l] = '0;
      end else begin
        m_cnt[idx] = c;
        m_w[idx]   = w;
        for (int l = 0; l < 4; l++) m_p[idx][l] = s[l];
      end
    end
  endtask

  function automatic logic [255:0] mk(input logic red, input logic [7:0] idx, input logic [7:0] w,
                                      input logic [31:0] l0, input logic [31:0] l1);
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = $urandom();
    f[255]     = 1'b1;
    f[254]     = red;
    f[135:128] = idx;
    f[151:144] = w;
    f[31:0]    = l0;
    f[63:32]   = l1;
    return f;
  endfunction

  // Presents one flit until accepted; returns at the negedge after acceptance.
  task automatic send(input logic [255:0] f);
    int g;
    g        = 0;
    in_data  = f;
    in_valid = 1'b1;
    #1;
    while (!in_ready && g < 300) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!in_ready) check_eq("send_timeout", 256'(in_ready), 256'(1));
    @(posedge clk);
    model_apply(f);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] idx, input logic [2:0] e);
    @(negedge clk);
    cfg_we     = 1'b1;
    cfg_index  = idx;
    cfg_expect = e;
    #1;
    check_eq("cfg_blocks_rdy", 256'(in_ready), 256'(0));
    @(posedge clk);
    m_exp[idx] = int'(e);
    m_cnt[idx] = 0;
    m_w[idx]   = 0;
    for (int l = 0; l < 4; l++) m_p[idx][l] = '0;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check_eq("drain_empty", 256'(exp_q.size()), 256'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_out(output logic [255:0] d);
    int g;
    g = 0;
    while (!out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    check_eq("wait_out_valid", 256'(out_valid), 256'(1));
    d = out_data;
  endtask

  // out_ready changes shortly after the rising edge so it is stable at every sample point.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: every valid cycle must show the oldest expected flit; pop on handshake.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 256'(out_valid), 256'(0));
      end else begin
        check_eq("out_data", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] f;
    logic [255:0] d;
    rst        = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    cfg_we     = 1'b0;
    cfg_index  = '0;
    cfg_expect = '0;
    model_clear();

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 256'(out_valid), 256'(0));
    check_eq("rst_in_ready", 256'(in_ready), 256'(0));
    check_eq("rst_out_data", out_data, 256'(0));
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_eq("rdy_after_rst", 256'(in_ready), 256'(1));

    // Pass-through latency: output appears exactly two cycles after acceptance.
    f = '0;
    f[255] = 1'b1;
    f[7:0] = 8'hAB;
    send(f);
    check_eq("pt_lat0", 256'(out_valid), 256'(0));
    @(negedge clk);
    check_eq("pt_lat1", 256'(out_valid), 256'(0));
    @(negedge clk);
    check_eq("pt_lat2", 256'(out_valid), 256'(1));
    check_eq("pt_data", out_data, f);
    drain();

    // Fan-in of three, back-to-back to the same index.
    do_cfg(8'd5, 3'd3);
    send(mk(1'b1, 8'd5, 8'd1, 32'd10, 32'd0));
    send(mk(1'b1, 8'd5, 8'd2, 32'd20, 32'd0));
    send(mk(1'b1, 8'd5, 8'd3, 32'd30, 32'd0));
    wait_out(d);
    check_eq("sum3_weight", 256'(d[151:144]), 256'(6));
    check_eq("sum3_lane0", 256'(d[31:0]), 256'(60));
    drain();
    // Entry must have restarted from zero.
    send(mk(1'b1, 8'd5, 8'd7, 32'd1, 32'd2));
    send(mk(1'b1, 8'd5, 8'd8, 32'd3, 32'd4));
    send(mk(1'b1, 8'd5, 8'd9, 32'd5, 32'd6));
    wait_out(d);
    check_eq("resum_weight", 256'(d[151:144]), 256'(24));
    drain();

    // Weight saturation and lane wrap without carry into the next lane.
    do_cfg(8'd7, 3'd2);
    send(mk(1'b1, 8'd7, 8'd200, 32'hFFFF_FFFF, 32'd5));
    send(mk(1'b1, 8'd7, 8'd100, 32'd2, 32'd6));
    wait_out(d);
    check_eq("sat_weight", 256'(d[151:144]), 256'(255));
    check_eq("wrap_lane0", 256'(d[31:0]), 256'(1));
    check_eq("wrap_lane1", 256'(d[63:32]), 256'(11));
    drain();

    // Back-pressure: pass-through then a single-flit completion, output held for 5 cycles.
    do_cfg(8'd11, 3'd1);
    rdy_mode = 2;
    @(negedge clk);
    send(mk(1'b0, 8'd11, 8'd4, 32'd1, 32'd1));
    send(mk(1'b1, 8'd11, 8'd5, 32'd2, 32'd2));
    repeat (5) begin
      @(negedge clk);
      #1;
      check_eq("stall_rdy", 256'(in_ready), 256'(0));
      check_eq("stall_valid", 256'(out_valid), 256'(1));
    end
    rdy_mode = 0;
    drain();

    // Config write on the same edge as a write-back (count 1->2) to that index.
    do_cfg(8'd9, 3'd3);
    send(mk(1'b1, 8'd9, 8'd1, 32'd100, 32'd0));
    send(mk(1'b1, 8'd9, 8'd2, 32'd200, 32'd0));
    do_cfg(8'd9, 3'd2);
    send(mk(1'b1, 8'd9, 8'd3, 32'd7, 32'd0));
    send(mk(1'b1, 8'd9, 8'd4, 32'd8, 32'd0));
    wait_out(d);
    check_eq("cfgwin_weight", 256'(d[151:144]), 256'(7));
    check_eq("cfgwin_lane0", 256'(d[31:0]), 256'(15));
    drain();

    // Reset with a partial sum in flight.
    do_cfg(8'd4, 3'd3);
    send(mk(1'b1, 8'd4, 8'd10, 32'd1000, 32'd0));
    send(mk(1'b1, 8'd4, 8'd20, 32'd2000, 32'd0));
    rst = 1'b0;
    model_clear();
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_eq("midrst_valid", 256'(out_valid), 256'(0));
    check_eq("midrst_rdy", 256'(in_ready), 256'(0));
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("postrst_idle", 256'(out_valid), 256'(0));
    do_cfg(8'd4, 3'd3);
    send(mk(1'b1, 8'd4, 8'd1, 32'd1, 32'd0));
    send(mk(1'b1, 8'd4, 8'd1, 32'd2, 32'd0));
    send(mk(1'b1, 8'd4, 8'd1, 32'd3, 32'd0));
    wait_out(d);
    check_eq("postrst_weight", 256'(d[151:144]), 256'(3));
    check_eq("postrst_lane0", 256'(d[31:0]), 256'(6));
    drain();

    // Randomized traffic over a few hot indices with random back-pressure.
    for (int i = 0; i < 8; i++) do_cfg(8'(i), 3'($urandom_range(0, 4)));
    rdy_mode = 1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] l0;
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
      end else begin
        l0 = ($urandom_range(0, 1) == 0) ? $urandom() : (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
        send(mk($urandom_range(0, 9) < 7, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                l0, $urandom()));
      end
    end
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
